// File: rtl/mux_pkg.sv
// Shared constants and types for the 4:1 mux path and its select arbiter.
package mux_pkg;

  localparam int unsigned N_IN  = 4;
  localparam int unsigned SEL_W = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // One-hot decode of a mux select code.
  function automatic logic [N_IN-1:0] onehot(input logic [SEL_W-1:0] idx);
    onehot = N_IN'(1) << idx;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Circular first-set search over four requests starting at a given index.
module rr_pick4
  import mux_pkg::*;
(
  input  logic [N_IN-1:0]  req,
  input  logic [SEL_W-1:0] start,
  output logic             found,
  output logic [SEL_W-1:0] idx
);

  logic [SEL_W-1:0] cand;

  // Walk offsets from farthest to nearest so the nearest set bit wins.
  always_comb begin
    found = |req;
    idx   = start;
    cand  = start;
    for (int k = int'(N_IN) - 1; k >= 0; k--) begin
      cand = start + SEL_W'(k);
      if (req[cand]) idx = cand;
    end
  end

endmodule

// File: rtl/rr_sel_arbiter4.sv
// Round-robin arbiter driving the 4:1 mux select with a minimum grant dwell.
module rr_sel_arbiter4
  import mux_pkg::*;
#(
  parameter int unsigned DWELL = 4,
  parameter int unsigned CW    = $clog2(DWELL + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IN-1:0]  req,
  input  logic             lock,
  output logic [SEL_W-1:0] sel,
  output logic [N_IN-1:0]  grant,
  output logic             valid,
  output logic             switch
);

  arb_state_t       state;
  arb_state_t       state_nxt;
  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] ptr_nxt;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_nxt;
  logic [SEL_W-1:0] sel_nxt;
  logic [N_IN-1:0]  grant_nxt;
  logic             valid_nxt;
  logic             switch_nxt;

  logic [SEL_W-1:0] start;
  logic             found;
  logic [SEL_W-1:0] idx;
  logic             dropped;
  logic             expired;
  logic             take;

  // Idle searches from the priority pointer, rotation searches past the holder.
  assign start   = (state == IDLE) ? ptr : sel + SEL_W'(1);
  assign dropped = !req[sel];
  assign expired = (cnt == CW'(DWELL)) && !lock;

  rr_pick4 u_pick (
    .req   (req),
    .start (start),
    .found (found),
    .idx   (idx)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state: enter GRANT on any request, leave only when the holder drops alone.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (found) state_nxt = GRANT;
      GRANT:   if (dropped && !found) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next output/datapath values; a drop outranks expiry, lock only blocks expiry.
  always_comb begin
    take       = 1'b0;
    sel_nxt    = sel;
    grant_nxt  = grant;
    valid_nxt  = valid;
    switch_nxt = 1'b0;
    cnt_nxt    = cnt;
    ptr_nxt    = ptr;
    case (state)
      IDLE: begin
        if (found) take = 1'b1;
      end
      GRANT: begin
        if (dropped) begin
          if (found) begin
            take = 1'b1;
          end else begin
            grant_nxt = '0;
            valid_nxt = 1'b0;
            cnt_nxt   = '0;
          end
        end else if (expired) begin
          take = 1'b1;
        end else begin
          cnt_nxt = (cnt == CW'(DWELL)) ? cnt : cnt + CW'(1);
        end
      end
      default: begin
        grant_nxt = '0;
        valid_nxt = 1'b0;
      end
    endcase
    if (take) begin
      sel_nxt    = idx;
      grant_nxt  = onehot(idx);
      valid_nxt  = 1'b1;
      switch_nxt = (idx != sel);
      cnt_nxt    = CW'(1);
      ptr_nxt    = idx + SEL_W'(1);
    end
  end

  // Output and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel    <= '0;
      grant  <= '0;
      valid  <= 1'b0;
      switch <= 1'b0;
      cnt    <= '0;
      ptr    <= '0;
    end else begin
      sel    <= sel_nxt;
      grant  <= grant_nxt;
      valid  <= valid_nxt;
      switch <= switch_nxt;
      cnt    <= cnt_nxt;
      ptr    <= ptr_nxt;
    end
  end

endmodule
